// File: rtl/fir_xifu_lsu_resp.sv
// XIFU memory response tracker: matches in-order XIF mem_result beats to issued
// loads/stores, hands load data to the regfile and reports bus/protocol errors.
module fir_xifu_lsu_resp #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [ID_W-1:0]          issue_id_i,
  input  logic [4:0]               issue_rd_i,
  input  logic                     issue_we_i,
  input  logic                     result_valid_i,
  input  logic [ID_W-1:0]          result_id_i,
  input  logic [31:0]              result_rdata_i,
  input  logic                     result_err_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [4:0]               wb_rd_o,
  output logic [31:0]              wb_data_o,
  output logic [ID_W-1:0]          wb_id_o,
  output logic                     err_o,
  output logic [1:0]               err_code_o,
  output logic [ID_W-1:0]          err_id_o,
  output logic [$clog2(DEPTH):0]   outstanding_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [ID_W-1:0] ent_id_r   [DEPTH];
  logic [4:0]      ent_rd_r   [DEPTH];
  logic [31:0]     ent_data_r [DEPTH];
  logic [DEPTH-1:0] ent_we_r, ent_done_r, ent_err_r, ent_mm_r;

  logic [PW-1:0]   alloc_ptr_r, rsp_ptr_r, ret_ptr_r, outstanding_r;
  logic            err_r;
  logic [1:0]      err_code_r;
  logic [ID_W-1:0] err_id_r;

  logic [AW-1:0]   alloc_idx_s, rsp_idx_s, ret_idx_s;
  logic [PW-1:0]   count_s, alloc_nxt_s, rsp_nxt_s, ret_nxt_s, cnt_nxt_s;
  logic            ready_s, do_issue_s, pending_s, spurious_s, do_rsp_s, mismatch_s;
  logic            head_done_s, wb_valid_s, retire_s, bus_err_s;

  // Pointer arithmetic, event decode and retire decision for this cycle
  always_comb begin
    alloc_idx_s = alloc_ptr_r[AW-1:0];
    rsp_idx_s   = rsp_ptr_r[AW-1:0];
    ret_idx_s   = ret_ptr_r[AW-1:0];
    count_s     = alloc_ptr_r - ret_ptr_r;
    ready_s     = (count_s != PW'(DEPTH));
    do_issue_s  = issue_valid_i & ready_s;
    pending_s   = (rsp_ptr_r != alloc_ptr_r);
    spurious_s  = result_valid_i & ~pending_s;
    do_rsp_s    = result_valid_i & pending_s;
    mismatch_s  = do_rsp_s & (result_id_i != ent_id_r[rsp_idx_s]);
    head_done_s = (ret_ptr_r != rsp_ptr_r) & ent_done_r[ret_idx_s];
    wb_valid_s  = head_done_s & ~ent_err_r[ret_idx_s] & ~ent_we_r[ret_idx_s];
    retire_s    = head_done_s & (ent_we_r[ret_idx_s] | ent_err_r[ret_idx_s] | wb_ready_i);
    // Mismatched entries were already reported when the result arrived
    bus_err_s   = head_done_s & ent_err_r[ret_idx_s] & ~ent_mm_r[ret_idx_s];
    alloc_nxt_s = alloc_ptr_r + {{AW{1'b0}}, do_issue_s};
    rsp_nxt_s   = rsp_ptr_r + {{AW{1'b0}}, do_rsp_s};
    ret_nxt_s   = ret_ptr_r + {{AW{1'b0}}, retire_s};
    cnt_nxt_s   = alloc_nxt_s - ret_nxt_s;
  end

  // Pointers, per-entry status flags and the registered occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_ptr_r   <= '0;
      rsp_ptr_r     <= '0;
      ret_ptr_r     <= '0;
      outstanding_r <= '0;
      ent_we_r      <= '0;
      ent_done_r    <= '0;
      ent_err_r     <= '0;
      ent_mm_r      <= '0;
    end else if (clear_i) begin
      alloc_ptr_r   <= '0;
      rsp_ptr_r     <= '0;
      ret_ptr_r     <= '0;
      outstanding_r <= '0;
      ent_done_r    <= '0;
      ent_err_r     <= '0;
      ent_mm_r      <= '0;
    end else begin
      if (do_issue_s) begin
        ent_we_r[alloc_idx_s]   <= issue_we_i;
        ent_done_r[alloc_idx_s] <= 1'b0;
        ent_err_r[alloc_idx_s]  <= 1'b0;
        ent_mm_r[alloc_idx_s]   <= 1'b0;
      end
      // rsp and alloc indices only coincide when full, where issue is blocked
      if (do_rsp_s) begin
        ent_done_r[rsp_idx_s] <= 1'b1;
        ent_err_r[rsp_idx_s]  <= mismatch_s | result_err_i;
        ent_mm_r[rsp_idx_s]   <= mismatch_s;
      end
      alloc_ptr_r   <= alloc_nxt_s;
      rsp_ptr_r     <= rsp_nxt_s;
      ret_ptr_r     <= ret_nxt_s;
      outstanding_r <= cnt_nxt_s;
    end
  end

  // Payload storage; needs no reset because the flags gate every use
  always_ff @(posedge clk_i) begin
    if (!clear_i && do_issue_s) begin
      ent_id_r[alloc_idx_s] <= issue_id_i;
      ent_rd_r[alloc_idx_s] <= issue_rd_i;
    end
    if (!clear_i && do_rsp_s) begin
      ent_data_r[rsp_idx_s] <= result_rdata_i;
    end
  end

  // Result-side errors are reported the cycle after the offending beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r      <= 1'b0;
      err_code_r <= 2'b00;
      err_id_r   <= '0;
    end else if (clear_i) begin
      err_r      <= 1'b0;
      err_code_r <= 2'b00;
      err_id_r   <= '0;
    end else if (spurious_s) begin
      err_r      <= 1'b1;
      err_code_r <= 2'b11;
      err_id_r   <= result_id_i;
    end else if (mismatch_s) begin
      err_r      <= 1'b1;
      err_code_r <= 2'b10;
      err_id_r   <= result_id_i;
    end else begin
      err_r      <= 1'b0;
      err_code_r <= 2'b00;
      err_id_r   <= '0;
    end
  end

  // Output drive; a pending result error outranks a bus error at retire
  always_comb begin
    issue_ready_o = ready_s;
    wb_valid_o    = wb_valid_s;
    wb_rd_o       = ent_rd_r[ret_idx_s];
    wb_data_o     = ent_data_r[ret_idx_s];
    wb_id_o       = ent_id_r[ret_idx_s];
    outstanding_o = outstanding_r;
    err_o         = 1'b0;
    err_code_o    = 2'b00;
    err_id_o      = '0;
    if (err_r) begin
      err_o      = 1'b1;
      err_code_o = err_code_r;
      err_id_o   = err_id_r;
    end else if (bus_err_s) begin
      err_o      = 1'b1;
      err_code_o = 2'b01;
      err_id_o   = ent_id_r[ret_idx_s];
    end else begin
      err_o      = 1'b0;
      err_code_o = 2'b00;
      err_id_o   = '0;
    end
  end

endmodule
